// File: rtl/gpu_pkg.sv
// Shared encodings for the core phase and fetcher state. These are used by core, pc and scheduler.
package gpu_pkg;

  localparam logic [2:0] CORE_IDLE    = 3'b000;
  localparam logic [2:0] CORE_FETCH   = 3'b001;
  localparam logic [2:0] CORE_DECODE  = 3'b010;
  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_WAIT    = 3'b100;
  localparam logic [2:0] CORE_EXECUTE = 3'b101;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;
  localparam logic [2:0] CORE_DONE    = 3'b111;

  localparam logic [2:0] FETCH_IDLE     = 3'b000;
  localparam logic [2:0] FETCH_FETCHING = 3'b001;
  localparam logic [2:0] FETCH_FETCHED  = 3'b010;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that saturates at all-ones and does not wrap.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset)                     count <= '0;
    else if (inc && (count != '1)) count <= count + 1'b1;
  end

endmodule

// File: rtl/instruction_fetcher.sv
// Per-core fetch unit. A one-entry PC-tagged buffer lets a repeated fetch of the
// same PC skip the memory round trip. Fetches and misses are counted.
module instruction_fetcher
  import gpu_pkg::*;
#(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int PERF_COUNTER_BITS     = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [PERF_COUNTER_BITS-1:0]     fetch_count,
  output logic [PERF_COUNTER_BITS-1:0]     miss_count
);

  logic                             buf_valid;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] buf_pc;
  logic [PROGRAM_MEM_DATA_BITS-1:0] buf_data;
  logic                             drop_fill;

  logic fetch_req, hit, miss, fill;

  assign fetch_req = (fetcher_state == FETCH_IDLE) && (core_state == CORE_FETCH);
  assign hit       = fetch_req && buf_valid && (buf_pc == current_pc) && !flush;
  assign miss      = fetch_req && !hit;
  assign fill      = (fetcher_state == FETCH_FETCHING) && mem_read_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetcher_state    <= FETCH_IDLE;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      instruction      <= '0;
      buf_valid        <= 1'b0;
      buf_pc           <= '0;
      buf_data         <= '0;
      drop_fill        <= 1'b0;
    end else begin
      case (fetcher_state)
        FETCH_IDLE: begin
          if (hit) begin
            instruction   <= buf_data;
            fetcher_state <= FETCH_FETCHED;
          end else if (miss) begin
            mem_read_valid   <= 1'b1;
            mem_read_address <= current_pc;
            fetcher_state    <= FETCH_FETCHING;
          end
        end
        FETCH_FETCHING: begin
          if (mem_read_ready) begin
            instruction    <= mem_read_data;
            mem_read_valid <= 1'b0;
            fetcher_state  <= FETCH_FETCHED;
            drop_fill      <= 1'b0;
            // A flush seen during the round trip means this data may predate the new kernel.
            if (!drop_fill && !flush) begin
              buf_pc    <= mem_read_address;
              buf_data  <= mem_read_data;
              buf_valid <= 1'b1;
            end
          end else if (flush) begin
            drop_fill <= 1'b1;
          end
        end
        FETCH_FETCHED: begin
          if (core_state == CORE_DECODE) fetcher_state <= FETCH_IDLE;
        end
        default: fetcher_state <= FETCH_IDLE;
      endcase
      // Placed last so a flush overrides a fill on the same edge.
      if (flush) buf_valid <= 1'b0;
    end
  end

  sat_counter #(.WIDTH(PERF_COUNTER_BITS)) u_fetch_count (
    .clk   (clk),
    .reset (reset),
    .inc   (hit || fill),
    .count (fetch_count)
  );

  sat_counter #(.WIDTH(PERF_COUNTER_BITS)) u_miss_count (
    .clk   (clk),
    .reset (reset),
    .inc   (miss),
    .count (miss_count)
  );

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed bench for instruction_fetcher. It uses a transaction-level reference model and checks every cycle.
// A second instance with 2-bit counters shares the stimulus so that saturation is reachable quickly.
module tb_instruction_fetcher;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  core_state = 3'b000;
  logic [7:0]  current_pc = 8'h00;
  logic        flush = 1'b0;
  logic        mem_read_ready = 1'b0;
  logic [15:0] mem_read_data = 16'h0000;

  logic        mem_read_valid, s_mem_read_valid;
  logic [7:0]  mem_read_address, s_mem_read_address;
  logic [2:0]  fetcher_state, s_fetcher_state;
  logic [15:0] instruction, s_instruction;
  logic [15:0] fetch_count, miss_count;
  logic [1:0]  s_fetch_count, s_miss_count;

  always #5 clk = ~clk;

  instruction_fetcher #(.PROGRAM_MEM_ADDR_BITS(8), .PROGRAM_MEM_DATA_BITS(16), .PERF_COUNTER_BITS(16)) dut (
    .clk(clk), .reset(reset), .core_state(core_state), .current_pc(current_pc), .flush(flush),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .fetcher_state(fetcher_state), .instruction(instruction),
    .fetch_count(fetch_count), .miss_count(miss_count));

  instruction_fetcher #(.PROGRAM_MEM_ADDR_BITS(8), .PROGRAM_MEM_DATA_BITS(16), .PERF_COUNTER_BITS(2)) dut_s (
    .clk(clk), .reset(reset), .core_state(core_state), .current_pc(current_pc), .flush(flush),
    .mem_read_valid(s_mem_read_valid), .mem_read_address(s_mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .fetcher_state(s_fetcher_state), .instruction(s_instruction),
    .fetch_count(s_fetch_count), .miss_count(s_miss_count));

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: one outstanding fetch, one cached (pc, word) pair, and unbounded event counts.
  int          m_phase = 0;   // 0 waiting for FETCH, 1 memory in flight, 2 word held
  logic        m_req = 1'b0;
  logic [7:0]  m_addr = 8'h00;
  logic [15:0] m_instr = 16'h0000;
  int          m_fetches = 0, m_misses = 0;
  logic        m_cached = 1'b0, m_stale = 1'b0;
  logic [7:0]  m_tag = 8'h00;
  logic [15:0] m_word = 16'h0000;
  bit          started = 1'b0;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  initial forever begin
    @(posedge clk);
    if (reset) begin
      started = 1'b1;
      m_phase = 0; m_req = 1'b0; m_addr = 8'h00; m_instr = 16'h0000;
      m_fetches = 0; m_misses = 0; m_cached = 1'b0; m_stale = 1'b0;
    end else begin
      if (m_phase == 0 && core_state == 3'b001) begin
        if (m_cached && m_tag == current_pc && !flush) begin
          m_instr = m_word; m_phase = 2; m_fetches++;
        end else begin
          m_req = 1'b1; m_addr = current_pc; m_phase = 1; m_misses++;
        end
      end else if (m_phase == 1) begin
        if (mem_read_ready) begin
          m_instr = mem_read_data; m_req = 1'b0; m_phase = 2; m_fetches++;
          if (!m_stale && !flush) begin
            m_cached = 1'b1; m_tag = m_addr; m_word = mem_read_data;
          end
          m_stale = 1'b0;
        end else if (flush) m_stale = 1'b1;
      end else if (m_phase == 2 && core_state == 3'b010) begin
        m_phase = 0;
      end
      if (flush) m_cached = 1'b0;
    end
  end

  always @(negedge clk) if (started) begin
    chk("state",    {29'd0, fetcher_state},  m_phase);
    chk("valid",    {31'd0, mem_read_valid}, {31'd0, m_req});
    chk("address",  {24'd0, mem_read_address}, {24'd0, m_addr});
    chk("instr",    {16'd0, instruction},    {16'd0, m_instr});
    chk("fetch_cnt", {16'd0, fetch_count},   sat(m_fetches, 16'hFFFF));
    chk("miss_cnt",  {16'd0, miss_count},    sat(m_misses, 16'hFFFF));
    chk("s_fetch_cnt", {30'd0, s_fetch_count}, sat(m_fetches, 3));
    chk("s_miss_cnt",  {30'd0, s_miss_count},  sat(m_misses, 3));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Complete one fetch. The lat argument is the count of edges after valid rises until ready is sampled.
  task automatic do_fetch(input logic [7:0] pc, input logic [15:0] data, input int lat,
                          input bit exp_miss, input bit flush_start, input bit flush_mid);
    int n;
    core_state = 3'b001; current_pc = pc; flush = flush_start;
    tick(1);
    flush = 1'b0;
    if (exp_miss) begin
      chk("req_valid", {31'd0, mem_read_valid}, 32'd1);
      chk("req_addr",  {24'd0, mem_read_address}, {24'd0, pc});
    end else begin
      chk("hit_fetched", {29'd0, fetcher_state}, 32'd2);
      chk("hit_no_req",  {31'd0, mem_read_valid}, 32'd0);
    end
    n = 0;
    while (fetcher_state != 3'b010 && n < 50) begin
      n++;
      if (n == lat) begin mem_read_ready = 1'b1; mem_read_data = data; end
      if (flush_mid && n == 1) flush = 1'b1;
      tick(1);
      mem_read_ready = 1'b0; flush = 1'b0;
    end
    if (n == 50) chk("fetch_timeout", {29'd0, fetcher_state}, 32'd2);
    tick(1);  // FETCH still asserted: the block must hold without a new request.
    chk("hold_no_req", {31'd0, mem_read_valid}, 32'd0);
    core_state = 3'b010;
    tick(1);
    core_state = 3'b000;
  endtask

  initial begin
    tick(2);
    chk("rst_state", {29'd0, fetcher_state}, 32'd0);
    chk("rst_valid", {31'd0, mem_read_valid}, 32'd0);
    chk("rst_instr", {16'd0, instruction}, 32'd0);
    chk("rst_fcnt",  {16'd0, fetch_count}, 32'd0);
    reset = 1'b0;

    do_fetch(8'h05, 16'h1234, 3, 1'b1, 1'b0, 1'b0);
    chk("s1_instr", {16'd0, instruction}, 32'h1234);
    chk("s1_miss",  {16'd0, miss_count}, 32'd1);
    chk("s1_fetch", {16'd0, fetch_count}, 32'd1);

    do_fetch(8'h05, 16'h0000, 1, 1'b0, 1'b0, 1'b0);
    chk("s2_instr", {16'd0, instruction}, 32'h1234);
    chk("s2_miss",  {16'd0, miss_count}, 32'd1);
    chk("s2_fetch", {16'd0, fetch_count}, 32'd2);

    do_fetch(8'h06, 16'h0006, 1, 1'b1, 1'b0, 1'b0);
    do_fetch(8'h05, 16'h1234, 2, 1'b1, 1'b0, 1'b0);
    chk("s3_miss",  {16'd0, miss_count}, 32'd3);
    chk("s3_fetch", {16'd0, fetch_count}, 32'd4);

    do_fetch(8'h07, 16'hBEEF, 3, 1'b1, 1'b0, 1'b1);
    chk("s4_instr", {16'd0, instruction}, 32'hBEEF);
    do_fetch(8'h07, 16'hBEEF, 1, 1'b1, 1'b0, 1'b0);
    do_fetch(8'h07, 16'hBEEF, 1, 1'b1, 1'b1, 1'b0);
    do_fetch(8'h07, 16'h0000, 1, 1'b0, 1'b0, 1'b0);
    chk("s4_miss",  {16'd0, miss_count}, 32'd6);
    chk("s4_fetch", {16'd0, fetch_count}, 32'd8);

    core_state = 3'b001; current_pc = 8'h09;
    tick(1);
    reset = 1'b1;
    tick(1);
    chk("s5_valid", {31'd0, mem_read_valid}, 32'd0);
    chk("s5_state", {29'd0, fetcher_state}, 32'd0);
    chk("s5_miss",  {16'd0, miss_count}, 32'd0);
    core_state = 3'b000; reset = 1'b0;
    mem_read_ready = 1'b1; mem_read_data = 16'hAAAA;
    tick(1);
    mem_read_ready = 1'b0;
    tick(1);
    chk("s5_late_instr", {16'd0, instruction}, 32'd0);
    chk("s5_late_state", {29'd0, fetcher_state}, 32'd0);

    do_fetch(8'h10, 16'h0010, 1, 1'b1, 1'b0, 1'b0);
    do_fetch(8'h11, 16'h0011, 2, 1'b1, 1'b0, 1'b0);
    chk("s6_near_sat", {30'd0, s_miss_count}, 32'd2);
    do_fetch(8'h12, 16'h0012, 1, 1'b1, 1'b0, 1'b0);
    do_fetch(8'hFF, 16'hCAFE, 1, 1'b1, 1'b0, 1'b0);
    chk("s6_sat_miss", {30'd0, s_miss_count}, 32'd3);
    do_fetch(8'hFF, 16'h0000, 1, 1'b0, 1'b0, 1'b0);
    chk("s6_ff_instr", {16'd0, instruction}, 32'hCAFE);
    chk("s6_sat_fetch", {30'd0, s_fetch_count}, 32'd3);
    chk("s6_miss",  {16'd0, miss_count}, 32'd4);
    chk("s6_fetch", {16'd0, fetch_count}, 32'd5);

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
